// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pixel-stream front end.
package sobel_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StGap,
    StDrain
  } stream_state_e;

endpackage

// File: rtl/sobel_raster_counter.sv
// Column/row raster counter with a linear address kept in step, so no multiplier is needed.
module sobel_raster_counter #(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8,
  parameter int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic              last_col,
  output logic              last_pixel,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_row;

  assign last_col   = (col_q == ColW'(IMG_WIDTH - 1));
  assign last_row   = (row_q == RowW'(IMG_HEIGHT - 1));
  assign last_pixel = last_col & last_row;
  assign addr       = addr_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      addr_d = last_pixel ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/sobel_frame_streamer.sv
// Reads one raster frame from a synchronous RAM and streams it to the Sobel detector.
// Optional inter-row idle gap is compiled in with SOBEL_STREAM_ROW_GAP_EN.
module sobel_frame_streamer
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 8,
  parameter int unsigned IMG_HEIGHT = 8,
  parameter int unsigned ROW_GAP    = 2,
  parameter int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  input  logic              pause,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  pixel_t            mem_rd_data,
  output logic              pix_start,
  output logic              pix_valid,
  output pixel_t            pix_data,
  output logic              frame_done,
  output logic              busy
);

  stream_state_e state_q, state_d;

  logic              issue;
  logic              cnt_clear;
  logic              last_col;
  logic              last_pixel;
  logic [ADDR_W-1:0] cnt_addr;

  // Read pipeline: stage 0 is the RAM access, stage 1 carries returned data.
  logic              mem_rd_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              last_rd_q;
  logic              rd1_q;
  logic              last1_q;
  logic              pix_valid_q;
  pixel_t            pix_data_q;
  logic              pix_start_q;
  logic              frame_done_q;

`ifdef SOBEL_STREAM_ROW_GAP_EN
  localparam int unsigned GapW = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
`endif

  sobel_raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_W    (ADDR_W)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .clear     (cnt_clear),
    .advance   (issue),
    .last_col  (last_col),
    .last_pixel(last_pixel),
    .addr      (cnt_addr)
  );

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    cnt_clear = 1'b0;
`ifdef SOBEL_STREAM_ROW_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (frame_req) begin
          state_d   = StStream;
          cnt_clear = 1'b1;
        end
      end
      StStream: begin
        if (!pause) begin
          issue = 1'b1;
          if (last_col) begin
            if (last_pixel) begin
              state_d = StDrain;
            end
`ifdef SOBEL_STREAM_ROW_GAP_EN
            else begin
              state_d   = StGap;
              gap_cnt_d = '0;
            end
`endif
          end
        end
      end
`ifdef SOBEL_STREAM_ROW_GAP_EN
      StGap: begin
        if (gap_cnt_q == GapW'(ROW_GAP - 1)) begin
          state_d = StStream;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
`endif
      // Leave one cycle after frame_done so busy drops after the last pixel.
      StDrain: begin
        if (frame_done_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
`ifdef SOBEL_STREAM_ROW_GAP_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef SOBEL_STREAM_ROW_GAP_EN
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      last_rd_q    <= 1'b0;
      rd1_q        <= 1'b0;
      last1_q      <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      mem_rd_en_q  <= issue;
      if (issue) begin
        mem_addr_q <= cnt_addr;
      end
      last_rd_q    <= issue & last_pixel;
      rd1_q        <= mem_rd_en_q;
      last1_q      <= last_rd_q;
      pix_valid_q  <= rd1_q;
      frame_done_q <= last1_q;
      if (rd1_q) begin
        pix_data_q <= mem_rd_data;
      end
      if (rd1_q) begin
        pix_start_q <= 1'b1;
      end else if (frame_done_q) begin
        pix_start_q <= 1'b0;
      end
    end
  end

  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_start  = pix_start_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != StIdle);

  ap_params: assert property (@(posedge clk) (IMG_WIDTH >= 3) && (IMG_HEIGHT >= 3) && (ROW_GAP >= 1));

endmodule

// File: doc/sobel_frame_streamer.md
# sobel_frame_streamer

Frame-buffer reader that drives the pixel-stream input of `sobel_edge_detector`. It sits between the image RAM and the detector. On each frame request it reads IMG_WIDTH×IMG_HEIGHT 8-bit pixels in raster order from a synchronous RAM. It presents them as a `start`/`valid`/`data` stream matching the detector's input protocol, then pulses `frame_done`.

## Interface
- IMG_WIDTH, 8, pixels per row (≥3)
- IMG_HEIGHT, 8, rows per frame (≥3)
- ROW_GAP, 2, idle cycles inserted between rows when gap feature compiled in (≥1)
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), RAM address width (derived; do not override)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- frame_req  in  1  start one frame; sampled only in IDLE
- pause  in  1  suppresses new RAM reads while high
- mem_rd_en  out  1  RAM read strobe (registered)
- mem_addr  out  ADDR_W  RAM read address, row*IMG_WIDTH+col (registered)
- mem_rd_data  in  8  RAM data, valid the cycle after mem_rd_en
- pix_start  out  1  to detector `start`; high from first through last pix_valid cycle of a frame
- pix_valid  out  1  to detector `pixel_valid`
- pix_data  out  8  to detector `pixel_in`
- frame_done  out  1  one-cycle pulse coincident with last pixel
- busy  out  1  high while state ≠ IDLE

## Operation
- FSM states: IDLE, STREAM, GAP, DRAIN.
- IDLE: on frame_req → STREAM; col=row=0. frame_req in any other state ignored.
- STREAM: each cycle with pause low at the edge, issue read at (row,col), advance col. On col==IMG_WIDTH-1:
  - last row → DRAIN
  - else with gap enabled → GAP
  - else → STREAM with col=0, row+1
- GAP: count ROW_GAP cycles (pause does not freeze the counter) → STREAM, next row.
- DRAIN: wait until the final in-flight read has emitted pix_valid; assert frame_done with it; → IDLE.
- Read pipeline: mem_rd_en delayed two stages produces pix_valid; mem_rd_data registered into pix_data. Pixel order equals address order; no pixel dropped or duplicated under any pause pattern.
- pix_data holds last value when pix_valid low.
- pix_start stays high through row gaps and pause holes within a frame; low otherwise.
- Reset (any time, including mid-frame): state IDLE, counters 0, all outputs 0 next cycle. No frame_done for an aborted frame.
- Reset values: mem_rd_en 0, mem_addr 0, pix_start 0, pix_valid 0, pix_data 0, frame_done 0, busy 0.

## Timing
- frame_req sampled at edge E0 → mem_rd_en high cycle 1 → data cycle 2 → pix_valid high cycle 3.
- Frame length with no pause and no gaps: W*H pixels back-to-back; last pix_valid at cycle 2+W*H. frame_done in the same cycle. busy falls the cycle after.
- pause high at edge E → no mem_rd_en in cycle E+1 → pix_valid hole two cycles later. Each paused cycle adds exactly one cycle.
- Back-to-back frames: frame_req accepted earliest the cycle busy is low; minimum 1 idle cycle between frames.

## Configuration
- SOBEL_STREAM_ROW_GAP_EN defined: GAP state present; ROW_GAP idle cycles between rows (not after last row). Frame takes W*H + (H-1)*ROW_GAP cycles plus pauses.
- Undefined: GAP state and counter removed; rows stream back-to-back; ROW_GAP ignored.

## Structure
- Shared package `sobel_pkg`: `pixel_t` (logic [7:0]), streamer state enum `stream_state_e`.
- One sub-module: `sobel_raster_counter` covers the col/row counters, the `advance` input, the `last_col`/`last_pixel` flags and the linear address output.

## Test plan
- 8×8, RAM data=addr, gaps off, pause low, frame_req pulse → 64 consecutive pix_valid, data 0..63, first 3 cycles after request edge, frame_done with data 63.
- Gaps on, ROW_GAP=2 → 7 holes of exactly 2 cycles after pixels 7,15,…,55. pix_start continuously high. Frame spans 78 valid-window cycles.
- pause high for 4 cycles during row 3 → single 4-cycle pix_valid hole. Sequence 0..63 intact. frame_done delayed 4 cycles.
- frame_req re-pulsed at pixel 10 → ignored. Exactly one frame of 64 pixels and one frame_done.
- rst asserted one cycle at pixel 20 → all outputs 0 next cycle, no frame_done. New frame_req restarts at address 0.
- Two frames separated by one idle cycle → 128 pixels, two frame_done pulses, pix_start low between frames.
